// File: rtl/ram_arbiter.sv
// Shares one synchronous RAM between a never-stalled CPU slot and a handshaked host port.
// Define RAMARB_DEFER_CNT_EN to add the saturating defer_count output.
module ram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_slot,
    input  logic        cpu_sel,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [12:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic [12:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
`ifdef RAMARB_DEFER_CNT_EN
    ,
    output logic [7:0]  defer_count
`endif
);

    typedef enum logic [1:0] {IDLE, PEND, RD, ACK} state_t;

    state_t      state_q, state_d;
    logic        h_we_q, h_we_d;
    logic [12:0] h_addr_q, h_addr_d;
    logic [7:0]  h_wdata_q, h_wdata_d;
    logic        host_ack_q, host_ack_d;
    logic [7:0]  host_rdata_q, host_rdata_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic        cpu_grant_q;
    logic        cpu_grant;

    assign cpu_grant = cpu_slot & cpu_sel;

    always_comb begin
        state_d      = state_q;
        h_we_d       = h_we_q;
        h_addr_d     = h_addr_q;
        h_wdata_d    = h_wdata_q;
        host_rdata_d = host_rdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        // The CPU read lands one cycle after its grant, whatever the host is doing.
        if (cpu_grant_q)
            cpu_rdata_d = ram_rdata;
        case (state_q)
            IDLE: begin
                if (host_req) begin
                    h_we_d    = host_we;
                    h_addr_d  = host_addr;
                    h_wdata_d = host_wdata;
                    state_d   = PEND;
                end
            end
            PEND: begin
                if (!cpu_grant)
                    state_d = h_we_q ? ACK : RD;
            end
            RD: begin
                host_rdata_d = ram_rdata;
                state_d      = ACK;
            end
            default: state_d = IDLE;
        endcase
        host_ack_d = (state_d == ACK);
    end

    // RAM port: CPU first, then a pending host access, otherwise an idle read of cpu_addr.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_we    = 1'b0;
        ram_wdata = cpu_wdata;
        if (cpu_grant) begin
            ram_we = cpu_we;
        end else if (state_q == PEND) begin
            ram_addr  = h_addr_q;
            ram_we    = h_we_q;
            ram_wdata = h_wdata_q;
        end
        if (reset)
            ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            h_we_q       <= 1'b0;
            h_addr_q     <= '0;
            h_wdata_q    <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
            cpu_rdata_q  <= '0;
            cpu_grant_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_we_q       <= h_we_d;
            h_addr_q     <= h_addr_d;
            h_wdata_q    <= h_wdata_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_grant_q  <= cpu_grant;
        end
    end

    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign cpu_rdata  = cpu_rdata_q;

`ifdef RAMARB_DEFER_CNT_EN
    logic [7:0] defer_q, defer_d;

    always_comb begin
        defer_d = defer_q;
        if (state_q == PEND && cpu_grant && defer_q != 8'hFF)
            defer_d = defer_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            defer_q <= '0;
        else
            defer_q <= defer_d;
    end

    assign defer_count = defer_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected RAM writes, host acks and
// CPU read data; a negedge monitor pops and compares as the DUT presents them.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_slot, cpu_sel, cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        host_req, host_we, host_ack;
    logic [12:0] host_addr;
    logic [7:0]  host_wdata, host_rdata;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata;
`ifdef RAMARB_DEFER_CNT_EN
    logic [7:0]  defer_count;
`endif

    ram_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_slot(cpu_slot), .cpu_sel(cpu_sel), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
`ifdef RAMARB_DEFER_CNT_EN
        , .defer_count(defer_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous read-first RAM model.
    logic [7:0] mem [0:8191];
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        int          cyc;
        logic [12:0] addr;
        logic [7:0]  data;
        bit          chk;
    } ev_t;

    ev_t wr_q[$];
    ev_t ack_q[$];
    ev_t cpu_q[$];

    always @(negedge clk) begin : monitor
        ev_t e;
        if (ram_we) begin
            if (wr_q.size() == 0) begin
                check("unexpected ram_we", 1, 0);
            end else begin
                e = wr_q.pop_front();
                check("ram_we cycle", cyc, e.cyc);
                check("ram_addr", int'(ram_addr), int'(e.addr));
                check("ram_wdata", int'(ram_wdata), int'(e.data));
            end
        end
        if (host_ack) begin
            if (ack_q.size() == 0) begin
                check("unexpected host_ack", 1, 0);
            end else begin
                e = ack_q.pop_front();
                check("host_ack cycle", cyc, e.cyc);
                if (e.chk)
                    check("host_rdata", int'(host_rdata), int'(e.data));
            end
        end
        if (cpu_q.size() != 0 && cpu_q[0].cyc <= cyc) begin
            e = cpu_q.pop_front();
            check("cpu_rdata cycle", cyc, e.cyc);
            check("cpu_rdata", int'(cpu_rdata), int'(e.data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One host access; optionally a CPU slot at cycle offset cpu_off from the request.
    task automatic host_access(input logic we, input logic [12:0] addr, input logic [7:0] wd,
                               input logic [7:0] rd_exp, input int cpu_off, input logic csel,
                               input logic [12:0] caddr, input logic [7:0] cpu_exp);
        int  c0;
        int  d;
        bit  got;
        c0  = cyc;
        d   = (cpu_off == 1 && csel) ? 1 : 0;
        got = 1'b0;
        if (we) begin
            wr_q.push_back('{c0 + 1 + d, addr, wd, 1'b1});
            ack_q.push_back('{c0 + 2 + d, 13'd0, 8'd0, 1'b0});
        end else begin
            ack_q.push_back('{c0 + 3 + d, 13'd0, rd_exp, 1'b1});
        end
        if (cpu_off >= 0)
            cpu_q.push_back('{c0 + cpu_off + 2, caddr, cpu_exp, 1'b1});
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wd;
        for (int k = 0; k < 20; k++) begin
            cpu_slot = (k == cpu_off);
            cpu_sel  = (k == cpu_off) && csel;
            cpu_we   = 1'b0;
            cpu_addr = caddr;
            @(negedge clk);
            if (host_ack) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got)
            check("host_ack timeout", 0, 1);
        host_req = 1'b0;
        cpu_slot = 1'b0;
        cpu_sel  = 1'b0;
        $display("[TB] host %s addr 0x%0h wdata 0x%0h rdata 0x%0h cpu_off %0d sel %0d",
                 we ? "wr" : "rd", addr, wd, host_rdata, cpu_off, csel);
        tick();
    endtask

    task automatic cpu_access(input logic we, input logic [12:0] addr, input logic [7:0] wd,
                              input logic [7:0] exp);
        if (we)
            wr_q.push_back('{cyc, addr, wd, 1'b1});
        cpu_q.push_back('{cyc + 2, addr, exp, 1'b1});
        cpu_slot  = 1'b1;
        cpu_sel   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        tick();
        cpu_slot = 1'b0;
        cpu_sel  = 1'b0;
        cpu_we   = 1'b0;
        tick();
        $display("[TB] cpu %s addr 0x%0h wdata 0x%0h rdata 0x%0h",
                 we ? "wr" : "rd", addr, wd, cpu_rdata);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        reset = 1'b1;
        cpu_slot = 1'b0; cpu_sel = 1'b0; cpu_we = 1'b0;
        cpu_addr = 13'h0; cpu_wdata = 8'h0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 13'h0; host_wdata = 8'h0;
        tick();
        tick();
        check("reset host_ack", int'(host_ack), 0);
        check("reset host_rdata", int'(host_rdata), 0);
        check("reset cpu_rdata", int'(cpu_rdata), 0);
        check("reset ram_we", int'(ram_we), 0);
`ifdef RAMARB_DEFER_CNT_EN
        check("reset defer_count", int'(defer_count), 0);
`endif
        reset = 1'b0;

        // Uncontended write then read.
        host_access(1'b1, 13'h1A5, 8'h3C, 8'h00, -1, 1'b0, 13'h0, 8'h00);
        host_access(1'b0, 13'h1A5, 8'h00, 8'h3C, -1, 1'b0, 13'h0, 8'h00);

        host_access(1'b1, 13'h0010, 8'h5A, 8'h00, -1, 1'b0, 13'h0, 8'h00);
        host_access(1'b1, 13'h0020, 8'h77, 8'h00, -1, 1'b0, 13'h0, 8'h00);
        host_access(1'b1, 13'h0100, 8'h11, 8'h00, -1, 1'b0, 13'h0, 8'h00);
        host_access(1'b1, 13'h0200, 8'h22, 8'h00, -1, 1'b0, 13'h0, 8'h00);

        // CPU read lands exactly on PEND: host deferred one cycle.
        host_access(1'b0, 13'h1A5, 8'h00, 8'h3C, 1, 1'b1, 13'h0010, 8'h5A);
`ifdef RAMARB_DEFER_CNT_EN
        check("defer_count after collision", int'(defer_count), 1);
`endif

        // Unselected slot on PEND: host proceeds, cpu_rdata holds.
        host_access(1'b0, 13'h0100, 8'h00, 8'h11, 1, 1'b0, 13'h0020, 8'h5A);

        // CPU data retention across host reads.
        cpu_access(1'b0, 13'h0020, 8'h00, 8'h77);
        host_access(1'b0, 13'h0100, 8'h00, 8'h11, -1, 1'b0, 13'h0, 8'h00);
        check("cpu_rdata retained 1", int'(cpu_rdata), 8'h77);
        host_access(1'b0, 13'h0200, 8'h00, 8'h22, -1, 1'b0, 13'h0, 8'h00);
        check("cpu_rdata retained 2", int'(cpu_rdata), 8'h77);

        // CPU write returns the old contents, then a CPU read sees the new value.
        cpu_access(1'b1, 13'h0030, 8'h99, 8'h00);
        cpu_access(1'b0, 13'h0030, 8'h00, 8'h99);

        // Reset while a host write sits in PEND.
        host_req = 1'b1; host_we = 1'b1; host_addr = 13'h0040; host_wdata = 8'hEE;
        tick();
        reset = 1'b1;
        host_req = 1'b0;
        #1;
        check("ram_we in reset", int'(ram_we), 0);
        tick();
        reset = 1'b0;
        check("post-reset host_ack", int'(host_ack), 0);
        check("post-reset host_rdata", int'(host_rdata), 0);
        check("post-reset cpu_rdata", int'(cpu_rdata), 0);
`ifdef RAMARB_DEFER_CNT_EN
        check("post-reset defer_count", int'(defer_count), 0);
`endif
        $display("[TB] reset during PEND write to 0x40");
        host_access(1'b0, 13'h0040, 8'h00, 8'h00, -1, 1'b0, 13'h0, 8'h00);

        tick();
        tick();
        check("wr_q drained", wr_q.size(), 0);
        check("ack_q drained", ack_q.size(), 0);
        check("cpu_q drained", cpu_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, system clock (cpu_clk domain); all state changes on its rising edge.
REQ-002 The block SHALL have these ports: reset, input, 1, reset, synchronous and active-high.
REQ-003 The block SHALL have these CPU-side ports: cpu_slot, input, 1, one-cycle pulse per CPU bus cycle (the cpu_clken1 timing).
REQ-004 The block SHALL have these CPU-side ports: cpu_sel, input, 1, CPU address decodes to RAM; cpu_we, input, 1, CPU write.
REQ-005 The block SHALL have these CPU-side ports: cpu_addr, input, 13, CPU address; cpu_wdata, input, 8, CPU write data.
REQ-006 The block SHALL have these CPU-side ports: cpu_rdata, output, 8, registered CPU read data.
REQ-007 The block SHALL have these host-side ports: host_req, input, 1; host_we, input, 1; host_addr, input, 13; host_wdata, input, 8.
REQ-008 The block SHALL have these host-side ports: host_ack, output, 1, one-cycle completion pulse; host_rdata, output, 8, registered host read data.
REQ-009 The block SHALL have these RAM-side ports: ram_addr, output, 13; ram_we, output, 1; ram_wdata, output, 8; ram_rdata, input, 8, synchronous read data valid the cycle after the address.
REQ-010 The block SHALL have this port when RAMARB_DEFER_CNT_EN is defined: defer_count, output, 8.

Function
REQ-011 A CPU grant SHALL occur in a cycle only when cpu_slot=1 and cpu_sel=1.
REQ-012 In a CPU grant cycle the RAM port SHALL be driven combinationally as ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata.
REQ-013 The CPU grant SHALL take absolute priority over any host access; the CPU SHALL never be stalled.
REQ-014 Following a CPU grant in cycle C, cpu_rdata SHALL load ram_rdata at the end of cycle C+1.
REQ-015 Following a CPU grant in cycle C, cpu_rdata SHALL hold its value until the next CPU grant, including across host reads.
REQ-016 Following a CPU grant in cycle C, cpu_rdata SHALL load on CPU writes as well (read-during-write value).
REQ-017 A cpu_slot with cpu_sel=0 SHALL NOT be a grant: cpu_rdata is unchanged and a host access may use that cycle.
REQ-018 The host FSM SHALL have four states: IDLE, PEND, RD, ACK.
REQ-019 In IDLE with host_req=1, the block SHALL latch host_we, host_addr and host_wdata and go to PEND.
REQ-020 Host inputs SHALL be ignored after latching until the FSM returns to IDLE.
REQ-021 In PEND during a CPU grant, the FSM SHALL stay in PEND (deferred).
REQ-022 In PEND without a CPU grant, the block SHALL drive the RAM port with the latched host access and go to RD if reading, or to ACK if writing.
REQ-023 In RD, host_rdata SHALL load ram_rdata and the FSM SHALL go to ACK.
REQ-024 In ACK, host_ack SHALL be 1 for exactly one cycle and the FSM SHALL go to IDLE; host_req sampled during ACK SHALL be ignored.
REQ-025 The host SHALL hold host_req until host_ack and then deassert it; a host_req still high in IDLE starts a new access.
REQ-026 Uncontended latency from host_req sampled in cycle C SHALL be: issue C+1, ack C+3 for a read; issue C+1, ack C+2 for a write.
REQ-027 Each CPU-grant deferral SHALL add exactly one cycle of host latency.
REQ-028 When no access is granted, the RAM port SHALL default to ram_addr=cpu_addr, ram_we=0, ram_wdata=cpu_wdata.
REQ-029 ram_we SHALL be asserted for at most one cycle per host write and SHALL never be asserted by the host and CPU in the same cycle.
REQ-030 host_rdata SHALL hold its value until the next host read completes.

Reset
REQ-031 On reset=1, the FSM SHALL go to IDLE and host_ack, host_rdata, cpu_rdata and defer_count SHALL be 0.
REQ-032 During reset=1, ram_we SHALL be 0.
REQ-033 A reset asserted mid-access SHALL abandon the access: no RAM write issues in the reset cycle and no host_ack is produced.
REQ-034 After reset, the FSM SHALL be in IDLE and SHALL respond to host_req on the first cycle reset is low.

Configuration
REQ-035 With RAMARB_DEFER_CNT_EN defined, defer_count SHALL increment by 1 on every cycle the FSM is in PEND during a CPU grant.
REQ-036 With RAMARB_DEFER_CNT_EN defined, defer_count SHALL saturate at 255 and clear only on reset.
REQ-037 Without RAMARB_DEFER_CNT_EN defined, the defer_count port and its counter SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-038 The bench SHALL cover an uncontended host write: host write 0x1A5 <- 0x3C -> ram_we=1 one cycle with addr 0x1A5 and data 0x3C, host_ack one cycle later.
REQ-039 The bench SHALL cover an uncontended host read: host read 0x1A5 (RAM holds 0x3C) -> host_rdata=0x3C and host_ack=1 three cycles after the req sample.
REQ-040 The bench SHALL cover a collision: host_req timed so PEND coincides with cpu_slot=1, cpu_sel=1, cpu read 0x0010 -> CPU issues first, host issues one cycle later, cpu_rdata=mem[0x0010], host ack delayed one cycle, and defer_count=1 when RAMARB_DEFER_CNT_EN is defined.
REQ-041 The bench SHALL cover a slot with cpu_sel=0 coinciding with PEND -> host issues in that cycle and cpu_rdata is unchanged.
REQ-042 The bench SHALL cover CPU data retention: CPU read 0x0020 (0x77), then back-to-back host reads of other addresses -> cpu_rdata stays 0x77 until the next CPU grant.
REQ-043 The bench SHALL cover reset in PEND with a host write latched -> no ram_we, no host_ack, FSM IDLE, all outputs 0.
